mem_fill_arbiter: RTL and testbench

- Shares the single-ported, pipelined main memory between I-cache miss fills, D-cache miss fills and D-side write-through stores.
- Sits between the two caches and main memory in the cached multi-cycle CPU; the core stalls while the corresponding request is pending.
- Sequences block fills: issues 8 word reads back-to-back, steers returned words into the requesting cache's data array, and writes the tag on the last word.

---
 rtl/mem_fill_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
// Arbitrates the single-ported pipelined main memory between I-cache fills,
// D-cache fills and D-side write-through stores; sequences 8-word block fills.
module mem_fill_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] fill_data,
  output logic [2:0]        fill_word,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_tag_we,
  output logic              d_tag_we,
  output logic              i_done,
  output logic              d_done,
  output logic              wr_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FILL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'(15);
  localparam logic [3:0]        WORDS     = 4'(WORDS_PER_BLOCK);
  localparam logic [3:0]        LAST_WORD = 4'(WORDS_PER_BLOCK - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_owner_d;
  logic [ADDR_W-1:0] r_base;
  logic [3:0]        r_issue_cnt;
  logic [3:0]        r_recv_cnt;

  logic w_issue;
  logic w_recv;
  logic w_last;

  // Returns are only meaningful inside a fill; stale ones in IDLE are dropped.
  assign w_issue = (r_state == S_FILL) && (r_issue_cnt < WORDS);
  assign w_recv  = (r_state == S_FILL) && mem_valid;
  assign w_last  = w_recv && (r_recv_cnt == LAST_WORD);

  // State register, winner latch and fill counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner_d   <= 1'b0;
      r_base      <= '0;
      r_issue_cnt <= 4'd0;
      r_recv_cnt  <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_issue_cnt <= 4'd0;
        r_recv_cnt  <= 4'd0;
        if (d_wr_req) begin
          r_owner_d <= 1'b1;
          r_base    <= d_wr_addr & BLK_MASK;
        end else if (d_miss) begin
          r_owner_d <= 1'b1;
          r_base    <= d_miss_addr & BLK_MASK;
        end else if (i_miss) begin
          r_owner_d <= 1'b0;
          r_base    <= i_miss_addr & BLK_MASK;
        end else begin
          r_owner_d <= r_owner_d;
          r_base    <= r_base;
        end
      end else begin
        if (w_issue) begin
          r_issue_cnt <= r_issue_cnt + 4'd1;
        end
        if (w_recv) begin
          r_recv_cnt <= r_recv_cnt + 4'd1;
        end
      end
    end
  end

  // Next-state logic; fixed priority store > D miss > I miss
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (d_wr_req) begin
          w_next = S_WRITE;
        end else if (d_miss || i_miss) begin
          w_next = S_FILL;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WRITE: w_next = S_IDLE;
      S_FILL: begin
        if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_FILL;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode; fill enables are steered only to the latched owner
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_data = '0;
    fill_word = 3'd0;
    i_fill_we = 1'b0;
    d_fill_we = 1'b0;
    i_tag_we  = 1'b0;
    d_tag_we  = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    wr_done   = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        mem_en = 1'b0;
      end
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        wr_done   = 1'b1;
      end
      S_FILL: begin
        if (w_issue) begin
          mem_en   = 1'b1;
          mem_addr = r_base | ADDR_W'({r_issue_cnt[2:0], 1'b0});
        end else begin
          mem_en = 1'b0;
        end
        if (w_recv) begin
          fill_data = mem_rdata;
          fill_word = r_recv_cnt[2:0];
          d_fill_we = r_owner_d;
          i_fill_we = ~r_owner_d;
          d_tag_we  = r_owner_d & w_last;
          i_tag_we  = ~r_owner_d & w_last;
        end else begin
          fill_word = 3'd0;
        end
      end
      S_DONE: begin
        d_done = r_owner_d;
        i_done = ~r_owner_d;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed testbench for mem_fill_arbiter with a latency-configurable
// in-order memory responder driven from the stimulus sequence.
module tb_mem_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_tag_we, d_tag_we;
  logic        i_done, d_done, wr_done, busy;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int lat  = 4;
  bit gap  = 1'b0;
  logic [15:0] q_addr[$];
  int          q_due[$];

  mem_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_tag_we(i_tag_we), .d_tag_we(d_tag_we),
    .i_done(i_done), .d_done(d_done), .wr_done(wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  function automatic logic [63:0] all_out();
    return {3'd0, mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
            i_fill_we, d_fill_we, i_tag_we, d_tag_we, i_done, d_done, wr_done, busy};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the settled mid-cycle point; advances one clock and drives memory returns.
  task automatic cycle();
    if (mem_en && !mem_wr) begin
      q_addr.push_back(mem_addr);
      q_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (q_addr.size() > 0 && q_due[0] <= cyc && (!gap || (cyc % 2 == 1))) begin
      mem_valid = 1'b1;
      mem_rdata = mdata(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      mem_valid = 1'b0;
      mem_rdata = 16'h0000;
    end
  endtask

  // Entered in the IDLE cycle where the request is visible; runs until owner's done.
  task automatic run_fill(input bit own_d, input logic [15:0] base, input int budget);
    int  iss, rcv;
    bit  done_seen;
    logic ofill, otag, odone;
    iss = 0; rcv = 0; done_seen = 1'b0;
    for (int k = 1; k <= budget && !done_seen; k++) begin
      cycle();
      #4;
      if (k == 1) chk("fill_start", {62'd0, mem_en, busy}, 64'd3);
      chk("nonowner_quiet", own_d ? {61'd0, i_fill_we, i_tag_we, i_done}
                                  : {61'd0, d_fill_we, d_tag_we, d_done}, 64'd0);
      ofill = own_d ? d_fill_we : i_fill_we;
      otag  = own_d ? d_tag_we  : i_tag_we;
      odone = own_d ? d_done    : i_done;
      if (mem_en) begin
        chk("rd_addr", {47'd0, mem_wr, mem_addr}, {48'd0, base + 16'(2 * iss)});
        iss++;
      end
      chk("fill_we_vs_valid", {63'd0, ofill}, {63'd0, mem_valid});
      if (ofill) begin
        chk("fill_word", {61'd0, fill_word}, 64'(rcv % 8));
        chk("fill_data", {48'd0, fill_data}, {48'd0, mdata(base + 16'(2 * rcv))});
        chk("tag_on_last", {63'd0, otag}, {63'd0, rcv == 7});
        rcv++;
      end else begin
        chk("tag_idle", {63'd0, otag}, 64'd0);
      end
      if (odone) begin
        done_seen = 1'b1;
        chk("fill_counts", 64'({iss[7:0], rcv[7:0]}), 64'h0808);
      end
    end
    chk("fill_timeout", {63'd0, done_seen}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
    i_miss_addr = 16'h0; d_miss_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0;
    mem_rdata = 16'h0; mem_valid = 1'b0;
    @(negedge clk);

    // Reset state
    for (int k = 0; k < 3; k++) begin
      cycle(); #4;
      chk("reset_outputs", all_out(), 64'd0);
    end
    cycle(); rst = 1'b0; #4;
    chk("idle_outputs", all_out(), 64'd0);

    // Single I miss with latency 4, cycle-exact
    cycle(); i_miss = 1'b1; i_miss_addr = 16'h1236; #4;
    chk("I_c0_idle", {62'd0, busy, mem_en}, 64'd0);
    for (int k = 1; k <= 14; k++) begin
      cycle();
      if (k == 14) i_miss = 1'b0;
      #4;
      chk("I_mem_en", {63'd0, mem_en}, {63'd0, k >= 1 && k <= 8});
      if (k >= 1 && k <= 8) chk("I_mem_addr", {48'd0, mem_addr}, 64'(16'h1230 + 16'(2 * (k - 1))));
      chk("I_fill_we", {63'd0, i_fill_we}, {63'd0, k >= 5 && k <= 12});
      if (k >= 5 && k <= 12) begin
        chk("I_fill_word", {61'd0, fill_word}, 64'(k - 5));
        chk("I_fill_data", {48'd0, fill_data}, {48'd0, mdata(16'h1230 + 16'(2 * (k - 5)))});
      end
      chk("I_tag_we", {63'd0, i_tag_we}, {63'd0, k == 12});
      chk("I_done", {63'd0, i_done}, {63'd0, k == 13});
      chk("I_busy", {63'd0, busy}, {63'd0, k <= 13});
      chk("I_d_side_quiet", {60'd0, d_fill_we, d_tag_we, d_done, wr_done}, 64'd0);
    end

    // Simultaneous store, D miss and I miss
    cycle();
    d_wr_req = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    d_miss = 1'b1; d_miss_addr = 16'h2000; i_miss = 1'b1; i_miss_addr = 16'h0100;
    #4;
    chk("S_idle", {62'd0, busy, mem_en}, 64'd0);
    cycle(); #4;
    chk("S_write", {29'd0, mem_en, mem_wr, wr_done, mem_addr, mem_wdata},
        {29'd0, 3'b111, 16'h0040, 16'hBEEF});
    cycle(); d_wr_req = 1'b0; #4;
    chk("S_idle_after_write", {61'd0, busy, mem_en, wr_done}, 64'd0);
    run_fill(1'b1, 16'h2000, 40);
    cycle(); d_miss = 1'b0; #4;
    chk("S_idle_before_i", {62'd0, busy, d_done}, 64'd0);
    run_fill(1'b0, 16'h0100, 40);
    cycle(); i_miss = 1'b0; #4;
    chk("S_back_idle", {63'd0, busy}, 64'd0);

    // Returns on alternate cycles only
    gap = 1'b1;
    cycle(); d_miss = 1'b1; d_miss_addr = 16'h7A1E; #4;
    run_fill(1'b1, 16'h7A10, 60);
    cycle(); d_miss = 1'b0; #4;
    gap = 1'b0;

    // Back-to-back D misses: one IDLE cycle between fills
    cycle(); d_miss = 1'b1; d_miss_addr = 16'h3008; #4;
    run_fill(1'b1, 16'h3000, 40);
    cycle(); d_miss_addr = 16'h4000; #4;
    chk("B2B_single_idle", {62'd0, busy, mem_en}, 64'd0);
    run_fill(1'b1, 16'h4000, 40);
    cycle(); d_miss = 1'b0; #4;

    // Reset in cycle 6 of a D fill
    cycle(); d_miss = 1'b1; d_miss_addr = 16'h5556; #4;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (k == 6) begin rst = 1'b1; d_miss = 1'b0; end
      #4;
      if (k == 5) chk("R_fill_started", {63'd0, d_fill_we}, 64'd1);
    end
    for (int k = 7; k <= 12; k++) begin
      cycle();
      rst = 1'b0;
      #4;
      chk("R_outputs_zero", all_out(), 64'd0);
    end
    chk("R_stale_drained", 64'(q_addr.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
